uart_rx: RTL

Asynchronous serial receiver, the receive half of the team's UART alongside the transmitter. It oversamples the `rx` line with the system clock and recovers start/data/parity/stop framing, LSB first. Each frame is delivered as a parallel word with a one-cycle `rx_valid` strobe, qualified by frame and parity error flags. It sits between the board pin (through its internal synchronizer) and whatever consumer logic or FIFO follows.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_sampler.sv | 72 +++++++
 rtl/uart_rx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_pkg                                               |
// | Description : Shared UART state encodings and bit-timing helpers     |
// |               used by uart_rx and uart_tx.                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    RECOVER = 3'd5
  } uart_state_t;

  // Last value of the bit counter; the counter spends this+1 clocks per bit
  function automatic int calc_cycles_per_bit(input int clk_hz, input int baud);
    return (clk_hz / baud) - 1;
  endfunction

  // Counter value at the middle of a bit, truncated
  function automatic int calc_half_bit(input int cycles_per_bit);
    return cycles_per_bit / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_rx_sampler                                        |
// | Description : Two-flop synchronizer, falling-edge detect and bit     |
// |               decision for uart_rx. With UART_RX_MAJORITY_EN the     |
// |               decision is a 2-of-3 vote around the sample point and  |
// |               arrives one clock after it; otherwise it is the single |
// |               synchronized sample taken at the sample point.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module uart_rx_sampler (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  input  logic sample_pt,
  output logic rx_s,
  output logic fall,
  output logic bit_ready,
  output logic bit_sample
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Synchronize the line and keep one cycle of history; idle-high reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign rx_s = r_sync2;
  assign fall = r_prev & ~r_sync2;

`ifdef UART_RX_MAJORITY_EN
  logic r_vote_pre;
  logic r_vote_mid;
  logic r_vote_rdy;

  // Capture the -1 and 0 samples; the +1 sample is the live rx_s next cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vote_pre <= 1'b1;
      r_vote_mid <= 1'b1;
      r_vote_rdy <= 1'b0;
    end else begin
      r_vote_rdy <= sample_pt;
      if (sample_pt) begin
        r_vote_pre <= r_prev;
        r_vote_mid <= r_sync2;
      end
    end
  end

  assign bit_ready  = r_vote_rdy;
  assign bit_sample = (r_vote_pre & r_vote_mid) |
                      (r_vote_pre & r_sync2)    |
                      (r_vote_mid & r_sync2);
`else
  assign bit_ready  = sample_pt;
  assign bit_sample = r_sync2;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_rx                                                |
// | Description : Oversampling UART receiver, LSB first, optional even   |
// |               parity, 1..2 stop bits. One-cycle rx_valid per frame   |
// |               with frame/parity error flags. Define                  |
// |               UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int INPUT_CLK     = 100_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int PAYLOAD_WIDTH = 8,
  parameter int STOP_BITS     = 1,
  parameter int PARITY_BIT    = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rx,
  output logic [PAYLOAD_WIDTH-1:0] rx_data,
  output logic                     rx_valid,
  output logic                     rx_busy,
  output logic                     frame_error,
  output logic                     parity_error
);

  localparam int          CYCLES_PER_BIT = calc_cycles_per_bit(INPUT_CLK, BAUD_RATE);
  localparam int          HALF_BIT       = calc_half_bit(CYCLES_PER_BIT);
  localparam logic [15:0] C_CPB          = 16'(CYCLES_PER_BIT);
  localparam logic [15:0] C_HALF         = 16'(HALF_BIT);
  localparam logic [3:0]  C_LAST_BIT     = 4'(PAYLOAD_WIDTH - 1);
  localparam logic        C_LAST_STOP    = (STOP_BITS == 2);

  if (CYCLES_PER_BIT >= 65536) begin : g_chk_cpb
    $error("uart_rx: CYCLES_PER_BIT does not fit the 16-bit bit counter");
  end
  if (PAYLOAD_WIDTH < 5 || PAYLOAD_WIDTH > 9) begin : g_chk_width
    $error("uart_rx: PAYLOAD_WIDTH must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_rx: STOP_BITS must be 1 or 2");
  end
`ifdef UART_RX_MAJORITY_EN
  if (CYCLES_PER_BIT < 4) begin : g_chk_majority
    $error("uart_rx: majority voting needs CYCLES_PER_BIT >= 4");
  end
`endif

  uart_state_t              r_state;
  uart_state_t              w_state_next;
  logic [15:0]              r_cnt;
  logic [3:0]               r_bit_cnt;
  logic                     r_stop_cnt;
  logic [PAYLOAD_WIDTH-1:0] r_shift;
  logic                     r_par_err;
  logic                     w_rx_s;
  logic                     w_fall;
  logic                     w_sample_pt;
  logic                     w_bit_ready;
  logic                     w_bit;
  logic                     w_complete;
  logic                     w_frame_err;

  uart_rx_sampler u_sampler (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .sample_pt  (w_sample_pt),
    .rx_s       (w_rx_s),
    .fall       (w_fall),
    .bit_ready  (w_bit_ready),
    .bit_sample (w_bit)
  );

  // Sample points: mid start bit, then once per full bit period
  assign w_sample_pt = (r_state == START)                    ? (r_cnt == C_HALF) :
                       (r_state inside {DATA, PARITY, STOP}) ? (r_cnt == C_CPB)  : 1'b0;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state and frame-completion decode; acts on each bit decision
  always_comb begin
    w_state_next = r_state;
    w_complete   = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      IDLE:    if (w_fall) w_state_next = START;
      START:   if (w_bit_ready) w_state_next = w_bit ? IDLE : DATA;
      DATA:    if (w_bit_ready && r_bit_cnt == C_LAST_BIT)
                 w_state_next = (PARITY_BIT != 0) ? PARITY : STOP;
      PARITY:  if (w_bit_ready) w_state_next = STOP;
      STOP: begin
        if (w_bit_ready) begin
          if (!w_bit) begin
            w_complete   = 1'b1;
            w_frame_err  = 1'b1;
            w_state_next = RECOVER;
          end else if (r_stop_cnt == C_LAST_STOP) begin
            w_complete   = 1'b1;
            w_state_next = IDLE;
          end
        end
      end
      RECOVER: if (w_rx_s) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Bit-period counter; restarts at each sample point so the period stays fixed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_cnt <= '0;
    else if (r_state == IDLE || w_state_next == IDLE || w_state_next == RECOVER)
      r_cnt <= '0;
    else if (w_sample_pt)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 16'd1;
  end

  // Shift data in LSB first, count bits and stop bits, accumulate parity
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par_err  <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
        r_par_err  <= 1'b0;
      end
      if (w_bit_ready) begin
        case (r_state)
          DATA: begin
            r_shift   <= {w_bit, r_shift[PAYLOAD_WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
          PARITY:  r_par_err  <= ^{r_shift, w_bit};
          STOP:    r_stop_cnt <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Frame completion registers the word and flags and pulses rx_valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      rx_valid <= w_complete;
      if (w_complete) begin
        rx_data      <= r_shift;
        frame_error  <= w_frame_err;
        parity_error <= r_par_err;
      end
    end
  end

  assign rx_busy = (r_state != IDLE);

endmodule
`default_nettype wire
